imem_fetch: RTL



---
 rtl/imem_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/imem_fetch.sv
// Instruction-memory fetch responder: synchronous single-port RAM with one-cycle
// read latency feeding a 2-entry output queue, with flush and host programming.
module imem_fetch #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   input  logic              flush,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_wdata,
   output logic [CNT_W-1:0]  fetch_count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic              rd_busy;
   logic [ADDR_W-1:0] rd_pc;

   // Queue: head entry drives the outputs directly, second entry stacks behind it.
   logic              h_valid;
   logic [DATA_W-1:0] h_data;
   logic [ADDR_W-1:0] h_pc;
   logic              s_valid;
   logic [DATA_W-1:0] s_data;
   logic [ADDR_W-1:0] s_pc;

   logic [1:0] occ;
   logic       pop;
   logic       pop_eff;
   logic       push;
   logic       accept;
   logic       load_h_from_s;
   logic       load_h_from_rd;
   logic       load_s_from_rd;
   logic       h_valid_nxt;
   logic       s_valid_nxt;

   always_comb begin
      occ       = {1'b0, h_valid} + {1'b0, s_valid} + {1'b0, rd_busy};
      pop       = h_valid & inst_ready;
      // Flush overrides a same-cycle pop and kills the returning read.
      pop_eff   = pop & ~flush;
      push      = rd_busy & ~flush;
      req_ready = ~flush & ~prog_we & ((occ < 2'd2) | pop);
      accept    = req_valid & req_ready;

      load_h_from_s  = pop_eff & s_valid;
      load_h_from_rd = push & (~h_valid | (pop_eff & ~s_valid));
      load_s_from_rd = push & h_valid & (s_valid ? pop_eff : ~pop_eff);

      h_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
      if (!flush) begin
         h_valid_nxt = load_h_from_s | load_h_from_rd | (h_valid & ~pop_eff);
         s_valid_nxt = load_s_from_rd | (s_valid & ~pop_eff);
      end
   end

   // NOTE: storage arrays carry no reset; only the valid flags guarding them do.
   always_ff @(posedge clk) begin
      if (prog_we)
         mem[prog_addr] <= prog_wdata;
      if (accept)
         rd_data <= mem[req_addr];
   end

   always_ff @(posedge clk) begin
      if (load_s_from_rd) begin
         s_data <= rd_data;
         s_pc   <= rd_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_busy     <= 1'b0;
         rd_pc       <= '0;
         h_valid     <= 1'b0;
         s_valid     <= 1'b0;
         h_data      <= '0;
         h_pc        <= '0;
         fetch_count <= '0;
      end else begin
         rd_busy <= accept;
         if (accept)
            rd_pc <= req_addr;
         h_valid <= h_valid_nxt;
         s_valid <= s_valid_nxt;
         if (load_h_from_s) begin
            h_data <= s_data;
            h_pc   <= s_pc;
         end else if (load_h_from_rd) begin
            h_data <= rd_data;
            h_pc   <= rd_pc;
         end
         fetch_count <= fetch_count + CNT_W'(pop_eff);
      end
   end

   assign inst_valid = h_valid;
   assign inst_data  = h_data;
   assign inst_pc    = h_pc;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && h_valid && s_valid && !pop_eff));

endmodule
